// File: rtl/sensor_poll_scheduler_pkg.sv
// Shared types for the sensor poll scheduler.
package sensor_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GAP_WAIT = 3'd1,
    START    = 3'd2,
    MEASURE  = 3'd3,
    RESULT   = 3'd4
  } state_e;

  typedef enum logic {
    SENS_DHT11  = 1'b0,
    SENS_HCSR04 = 1'b1
  } sensor_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01
  } status_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sensor_poll_scheduler_if.sv
// Bundle of the scheduler's command, sensor and result signals.
interface sensor_poll_scheduler_if;
  logic        cmd_req;
  logic        cmd_sel;
  logic        cmd_ack;
  logic        auto_en;
  logic        dht11_start;
  logic [15:0] dht11_data;
  logic        dht11_data_available;
  logic        hc_sr04_start;
  logic [15:0] hc_sr04_data;
  logic        hc_sr04_data_available;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_src;
  logic [1:0]  res_status;
  logic        busy;

  modport master (
    output cmd_ack, dht11_start, hc_sr04_start, res_valid, res_data, res_src,
           res_status, busy,
    input  cmd_req, cmd_sel, auto_en, dht11_data, dht11_data_available,
           hc_sr04_data, hc_sr04_data_available, res_ready
  );

  modport slave (
    input  cmd_ack, dht11_start, hc_sr04_start, res_valid, res_data, res_src,
           res_status, busy,
    output cmd_req, cmd_sel, auto_en, dht11_data, dht11_data_available,
           hc_sr04_data, hc_sr04_data_available, res_ready
  );
endinterface

// File: rtl/sensor_poll_scheduler_counter.sv
// Up-counter with clear, enable, saturate-or-wrap and a terminal-value flag.
module sched_counter
  import sensor_sched_pkg::*;
#(
  parameter int unsigned MAX        = 1,
  parameter bit          WRAP       = 1'b0,
  parameter bit          RST_AT_MAX = 1'b0,
  parameter bit          EARLY      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int unsigned W     = cnt_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d, base;

  // Clear and count combine: a cleared counter that is enabled reads 1 next cycle.
  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (en_i) begin
      if (base == MAX_V) cnt_d = WRAP ? '0 : MAX_V;
      else               cnt_d = base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= RST_AT_MAX ? MAX_V : '0;
    else      cnt_q <= cnt_d;
  end

  // EARLY flags the terminal value one cycle ahead so a decision lands on time.
  assign hit_o = EARLY ? (cnt_d == MAX_V) : (cnt_q == MAX_V);
endmodule

// File: rtl/sensor_poll_scheduler.sv
// Arbitrates command and auto-poll requests onto the DHT11 / HC-SR04 front-ends.
module sensor_poll_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int unsigned DHT_GAP_CYC     = 100_000_000,
  parameter int unsigned TIMEOUT_CYC     = 5_000_000,
  parameter int unsigned AUTO_PERIOD_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_req,
  input  logic        cmd_sel,
  output logic        cmd_ack,
  input  logic        auto_en,
  output logic        dht11_start,
  input  logic [15:0] dht11_data,
  input  logic        dht11_data_available,
  output logic        hc_sr04_start,
  input  logic [15:0] hc_sr04_data,
  input  logic        hc_sr04_data_available,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_src,
  output logic [1:0]  res_status,
  output logic        busy
);
  localparam int unsigned TO_MAX   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int unsigned AUTO_MAX = (AUTO_PERIOD_CYC > 0) ? AUTO_PERIOD_CYC - 1 : 0;
  localparam bit          AUTO_ON  = (AUTO_PERIOD_CYC > 0);

  state_e      state_q, state_d;
  sensor_e     sel_q, sel_d;
  sensor_e     auto_next_q, auto_next_d;
  logic        auto_pend_q, auto_pend_d;
  logic        ack_q, ack_d;
  logic [15:0] res_data_q, res_data_d;
  status_e     res_status_q, res_status_d;

  logic gap_ok, to_hit, per_hit;
  logic gap_clr, auto_ok, auto_tick, auto_take;
  logic strobe;
  logic [15:0] sel_data;

  assign gap_clr   = (state_q == START) && (sel_q == SENS_DHT11);
  assign auto_ok   = AUTO_ON && auto_en;
  assign auto_tick = auto_ok && per_hit;
  assign strobe    = (sel_q == SENS_DHT11) ? dht11_data_available : hc_sr04_data_available;
  assign sel_data  = (sel_q == SENS_DHT11) ? dht11_data : hc_sr04_data;

  // gap_ok is the look-ahead flag: a start issued next cycle meets the gap exactly.
  sched_counter #(.MAX(DHT_GAP_CYC), .WRAP(1'b0), .RST_AT_MAX(1'b1), .EARLY(1'b1)) u_gap (
    .clk(clk), .rst(rst), .clr_i(gap_clr), .en_i(1'b1), .hit_o(gap_ok)
  );

  sched_counter #(.MAX(TO_MAX), .WRAP(1'b0), .RST_AT_MAX(1'b0), .EARLY(1'b0)) u_timeout (
    .clk(clk), .rst(rst), .clr_i(state_q == START), .en_i(1'b1), .hit_o(to_hit)
  );

  sched_counter #(.MAX(AUTO_MAX), .WRAP(1'b1), .RST_AT_MAX(1'b0), .EARLY(1'b0)) u_period (
    .clk(clk), .rst(rst), .clr_i(!auto_ok), .en_i(auto_ok), .hit_o(per_hit)
  );

  always_comb begin
    logic go;
    go           = 1'b0;
    state_d      = state_q;
    sel_d        = sel_q;
    ack_d        = 1'b0;
    auto_take    = 1'b0;
    res_data_d   = res_data_q;
    res_status_d = res_status_q;
    case (state_q)
      IDLE: begin
        if (cmd_req) begin
          sel_d = sensor_e'(cmd_sel);
          ack_d = 1'b1;
          go    = 1'b1;
        end else if (auto_pend_q) begin
          sel_d     = auto_next_q;
          auto_take = 1'b1;
          go        = 1'b1;
        end
        if (go) state_d = (sel_d == SENS_HCSR04 || gap_ok) ? START : GAP_WAIT;
      end
      GAP_WAIT: if (gap_ok) state_d = START;
      START:    state_d = MEASURE;
      MEASURE: begin
        if (strobe) begin
          res_data_d   = sel_data;
          res_status_d = ST_OK;
          state_d      = RESULT;
        end else if (to_hit) begin
          res_data_d   = '0;
          res_status_d = ST_TIMEOUT;
          state_d      = RESULT;
        end
      end
      RESULT:   if (res_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    auto_pend_d = auto_pend_q;
    auto_next_d = auto_next_q;
    if (!auto_ok)       auto_pend_d = 1'b0;
    else if (auto_tick) auto_pend_d = 1'b1;
    else if (auto_take) auto_pend_d = 1'b0;
    if (auto_take) auto_next_d = (auto_next_q == SENS_DHT11) ? SENS_HCSR04 : SENS_DHT11;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sel_q        <= SENS_DHT11;
      auto_next_q  <= SENS_DHT11;
      auto_pend_q  <= 1'b0;
      ack_q        <= 1'b0;
      res_data_q   <= '0;
      res_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      auto_next_q  <= auto_next_d;
      auto_pend_q  <= auto_pend_d;
      ack_q        <= ack_d;
      res_data_q   <= res_data_d;
      res_status_q <= res_status_d;
    end
  end

  assign cmd_ack       = ack_q;
  assign dht11_start   = (state_q == START) && (sel_q == SENS_DHT11);
  assign hc_sr04_start = (state_q == START) && (sel_q == SENS_HCSR04);
  assign res_valid     = (state_q == RESULT);
  assign res_data      = res_data_q;
  assign res_src       = sel_q;
  assign res_status    = res_status_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler; instance a has auto-poll off, b has a 200-cycle period.
module tb_sensor_poll_scheduler;
  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  int unsigned log_cyc[$];
  logic        log_hc[$];

  sensor_poll_scheduler_if ia();
  sensor_poll_scheduler_if ib();

  sensor_poll_scheduler #(.DHT_GAP_CYC(50), .TIMEOUT_CYC(100), .AUTO_PERIOD_CYC(0)) u_a (
    .clk(clk), .rst(rst),
    .cmd_req(ia.cmd_req), .cmd_sel(ia.cmd_sel), .cmd_ack(ia.cmd_ack), .auto_en(ia.auto_en),
    .dht11_start(ia.dht11_start), .dht11_data(ia.dht11_data),
    .dht11_data_available(ia.dht11_data_available),
    .hc_sr04_start(ia.hc_sr04_start), .hc_sr04_data(ia.hc_sr04_data),
    .hc_sr04_data_available(ia.hc_sr04_data_available),
    .res_valid(ia.res_valid), .res_ready(ia.res_ready), .res_data(ia.res_data),
    .res_src(ia.res_src), .res_status(ia.res_status), .busy(ia.busy)
  );

  sensor_poll_scheduler #(.DHT_GAP_CYC(50), .TIMEOUT_CYC(100), .AUTO_PERIOD_CYC(200)) u_b (
    .clk(clk), .rst(rst),
    .cmd_req(ib.cmd_req), .cmd_sel(ib.cmd_sel), .cmd_ack(ib.cmd_ack), .auto_en(ib.auto_en),
    .dht11_start(ib.dht11_start), .dht11_data(ib.dht11_data),
    .dht11_data_available(ib.dht11_data_available),
    .hc_sr04_start(ib.hc_sr04_start), .hc_sr04_data(ib.hc_sr04_data),
    .hc_sr04_data_available(ib.hc_sr04_data_available),
    .res_valid(ib.res_valid), .res_ready(ib.res_ready), .res_data(ib.res_data),
    .res_src(ib.res_src), .res_status(ib.res_status), .busy(ib.busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ib.dht11_start === 1'b1 || ib.hc_sr04_start === 1'b1) begin
      log_cyc.push_back(cyc);
      log_hc.push_back(ib.hc_sr04_start);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic goto(input int unsigned k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    ia.cmd_req = 0; ia.cmd_sel = 0; ia.auto_en = 0; ia.dht11_data = '0;
    ia.dht11_data_available = 0; ia.hc_sr04_data = '0; ia.hc_sr04_data_available = 0;
    ia.res_ready = 1;
    ib.cmd_req = 0; ib.cmd_sel = 0; ib.auto_en = 0; ib.dht11_data = '0;
    ib.dht11_data_available = 0; ib.hc_sr04_data = '0; ib.hc_sr04_data_available = 0;
    ib.res_ready = 1;
    rst = 1'b1;
    #1 rst = 1'b0;
    goto(3);
    obs = {ia.cmd_ack, ia.dht11_start, ia.hc_sr04_start, ia.res_valid, ia.res_data,
           ia.res_src, ia.res_status, ia.busy};
    checks++;
    if (obs !== 24'h0) begin failures++; $display("FAIL reset_outputs_a: got %h expected 000000", obs); end
    obs = {ib.cmd_ack, ib.dht11_start, ib.hc_sr04_start, ib.res_valid, ib.res_data,
           ib.res_src, ib.res_status, ib.busy};
    checks++;
    if (obs !== 24'h0) begin failures++; $display("FAIL reset_outputs_b: got %h expected 000000", obs); end
    rst = 1'b1;
    goto(5);
  endtask

  task automatic test_dht_cmd();
    int unsigned t;
    t = cyc + 2;
    goto(t);
    ia.cmd_req = 1; ia.cmd_sel = 0; ia.dht11_data = 16'h1616;
    goto(t + 1);
    checks++;
    if ({ia.cmd_ack, ia.dht11_start, ia.hc_sr04_start, ia.busy} !== 4'b1101) begin
      failures++;
      $display("FAIL dht_ack_start: got %b expected 1101",
               {ia.cmd_ack, ia.dht11_start, ia.hc_sr04_start, ia.busy});
    end
    ia.cmd_req = 0;
    goto(t + 2);
    checks++;
    if ({ia.cmd_ack, ia.dht11_start} !== 2'b00) begin
      failures++; $display("FAIL dht_pulse_width: got %b expected 00", {ia.cmd_ack, ia.dht11_start});
    end
    goto(t + 11);
    ia.dht11_data_available = 1;
    goto(t + 12);
    ia.dht11_data_available = 0;
    checks++;
    if ({ia.res_valid, ia.res_data, ia.res_src, ia.res_status} !== {1'b1, 16'h1616, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL dht_result: got v=%b d=%h s=%b st=%b expected v=1 d=1616 s=0 st=00",
               ia.res_valid, ia.res_data, ia.res_src, ia.res_status);
    end
    goto(t + 13);
    checks++;
    if ({ia.res_valid, ia.busy} !== 2'b00) begin
      failures++; $display("FAIL dht_idle: got valid/busy=%b expected 00", {ia.res_valid, ia.busy});
    end
  endtask

  task automatic test_gap();
    int unsigned u;
    int unsigned stray;
    stray = 0;
    u = cyc + 60;
    goto(u);
    ia.cmd_req = 1; ia.cmd_sel = 0; ia.dht11_data = 16'h0042;
    goto(u + 1);
    ia.cmd_req = 0;
    checks++;
    if (ia.dht11_start !== 1'b1) begin failures++; $display("FAIL gap_first_start: got %b expected 1", ia.dht11_start); end
    goto(u + 2);
    ia.dht11_data_available = 1;
    goto(u + 3);
    ia.dht11_data_available = 0;
    goto(u + 6);
    ia.cmd_req = 1; ia.cmd_sel = 0;
    goto(u + 7);
    ia.cmd_req = 0;
    checks++;
    if ({ia.cmd_ack, ia.dht11_start, ia.busy} !== 3'b101) begin
      failures++; $display("FAIL gap_wait_entry: got %b expected 101", {ia.cmd_ack, ia.dht11_start, ia.busy});
    end
    for (int unsigned c = u + 7; c <= u + 50; c++) begin
      goto(c);
      if (ia.dht11_start !== 1'b0 || ia.busy !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin failures++; $display("FAIL gap_hold: got %0d early/idle cycles expected 0", stray); end
    goto(u + 51);
    checks++;
    if (ia.dht11_start !== 1'b1) begin failures++; $display("FAIL gap_second_start: got %b expected 1", ia.dht11_start); end
    goto(u + 53);
    ia.dht11_data_available = 1;
    goto(u + 54);
    ia.dht11_data_available = 0;
    goto(u + 56);
    checks++;
    if (ia.busy !== 1'b0) begin failures++; $display("FAIL gap_done: got busy=%b expected 0", ia.busy); end
  endtask

  task automatic test_timeout();
    int unsigned v;
    v = cyc + 2;
    goto(v);
    ia.cmd_req = 1; ia.cmd_sel = 1;
    goto(v + 1);
    ia.cmd_req = 0;
    checks++;
    if ({ia.hc_sr04_start, ia.dht11_start} !== 2'b10) begin
      failures++; $display("FAIL hc_start: got %b expected 10", {ia.hc_sr04_start, ia.dht11_start});
    end
    goto(v + 30);
    ia.dht11_data = 16'hBEEF; ia.dht11_data_available = 1;
    goto(v + 31);
    ia.dht11_data_available = 0;
    goto(v + 100);
    checks++;
    if (ia.res_valid !== 1'b0) begin failures++; $display("FAIL timeout_early: got valid=%b expected 0", ia.res_valid); end
    goto(v + 101);
    checks++;
    if ({ia.res_valid, ia.res_data, ia.res_src, ia.res_status} !== {1'b1, 16'h0000, 1'b1, 2'b01}) begin
      failures++;
      $display("FAIL timeout_result: got v=%b d=%h s=%b st=%b expected v=1 d=0000 s=1 st=01",
               ia.res_valid, ia.res_data, ia.res_src, ia.res_status);
    end
    goto(v + 102);
  endtask

  task automatic test_strobe_at_timeout();
    int unsigned x;
    x = cyc + 2;
    goto(x);
    ia.cmd_req = 1; ia.cmd_sel = 1; ia.hc_sr04_data = 16'h0A5A;
    goto(x + 1);
    ia.cmd_req = 0;
    goto(x + 100);
    ia.hc_sr04_data_available = 1;
    goto(x + 101);
    ia.hc_sr04_data_available = 0;
    checks++;
    if ({ia.res_valid, ia.res_data, ia.res_status} !== {1'b1, 16'h0A5A, 2'b00}) begin
      failures++;
      $display("FAIL strobe_vs_timeout: got v=%b d=%h st=%b expected v=1 d=0a5a st=00",
               ia.res_valid, ia.res_data, ia.res_status);
    end
    goto(x + 102);
  endtask

  task automatic test_backpressure();
    int unsigned w;
    int unsigned bad;
    bad = 0;
    w = cyc + 2;
    goto(w);
    ia.res_ready = 0; ia.cmd_req = 1; ia.cmd_sel = 1; ia.hc_sr04_data = 16'd3214;
    goto(w + 1);
    ia.cmd_req = 0;
    goto(w + 3);
    ia.hc_sr04_data_available = 1;
    goto(w + 4);
    ia.hc_sr04_data_available = 0; ia.hc_sr04_data = 16'h1111;
    for (int unsigned c = w + 4; c <= w + 23; c++) begin
      goto(c);
      if (c == w + 5) begin ia.cmd_req = 1; ia.cmd_sel = 0; end
      if (ia.res_valid !== 1'b1 || ia.res_data !== 16'd3214 || ia.res_src !== 1'b1 ||
          ia.res_status !== 2'b00 || ia.cmd_ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    goto(w + 24);
    checks++;
    if (ia.res_valid !== 1'b1) begin failures++; $display("FAIL bp_hold: got valid=%b expected 1", ia.res_valid); end
    ia.res_ready = 1;
    goto(w + 25);
    checks++;
    if ({ia.res_valid, ia.cmd_ack} !== 2'b00) begin
      failures++; $display("FAIL bp_release: got %b expected 00", {ia.res_valid, ia.cmd_ack});
    end
    goto(w + 26);
    ia.cmd_req = 0;
    checks++;
    if ({ia.cmd_ack, ia.dht11_start} !== 2'b11) begin
      failures++; $display("FAIL bp_next_cmd: got %b expected 11", {ia.cmd_ack, ia.dht11_start});
    end
    goto(w + 28);
    ia.dht11_data_available = 1;
    goto(w + 29);
    ia.dht11_data_available = 0;
    goto(w + 31);
  endtask

  task automatic test_auto();
    int unsigned p;
    int unsigned exp_cyc[5];
    logic        exp_hc[5];
    p = cyc + 2;
    exp_cyc[0] = p + 201; exp_hc[0] = 1'b0;
    exp_cyc[1] = p + 401; exp_hc[1] = 1'b1;
    exp_cyc[2] = p + 601; exp_hc[2] = 1'b0;
    exp_cyc[3] = p + 801; exp_hc[3] = 1'b0;
    exp_cyc[4] = p + 903; exp_hc[4] = 1'b1;
    log_cyc.delete();
    log_hc.delete();
    goto(p);
    ib.auto_en = 1; ib.res_ready = 1;
    goto(p + 800);
    ib.cmd_req = 1; ib.cmd_sel = 0;
    goto(p + 801);
    ib.cmd_req = 0;
    checks++;
    if ({ib.cmd_ack, ib.dht11_start} !== 2'b11) begin
      failures++; $display("FAIL auto_cmd_first: got %b expected 11", {ib.cmd_ack, ib.dht11_start});
    end
    goto(p + 910);
    ib.auto_en = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      checks++;
      if (i >= log_cyc.size()) begin
        failures++; $display("FAIL auto_start_%0d: got no pulse expected cycle %0d", i, exp_cyc[i]);
      end else if (log_cyc[i] !== exp_cyc[i] || log_hc[i] !== exp_hc[i]) begin
        failures++;
        $display("FAIL auto_start_%0d: got cycle %0d hc=%b expected cycle %0d hc=%b",
                 i, log_cyc[i], log_hc[i], exp_cyc[i], exp_hc[i]);
      end
    end
    goto(p + 1010);
  endtask

  task automatic test_reset_mid();
    int unsigned r;
    int unsigned bad;
    logic [23:0] obs;
    bad = 0;
    r = cyc + 60;
    goto(r);
    ia.cmd_req = 1; ia.cmd_sel = 0; ia.dht11_data = 16'h7777;
    goto(r + 1);
    ia.cmd_req = 0;
    goto(r + 5);
    rst = 1'b0;
    #1;
    obs = {ia.cmd_ack, ia.dht11_start, ia.hc_sr04_start, ia.res_valid, ia.res_data,
           ia.res_src, ia.res_status, ia.busy};
    checks++;
    if (obs !== 24'h0) begin failures++; $display("FAIL midreset_outputs: got %h expected 000000", obs); end
    goto(r + 7);
    rst = 1'b1;
    goto(r + 10);
    ia.dht11_data_available = 1;
    goto(r + 11);
    ia.dht11_data_available = 0;
    for (int unsigned c = r + 11; c <= r + 20; c++) begin
      goto(c);
      if (ia.res_valid !== 1'b0 || ia.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midreset_ignore: got %0d active cycles expected 0", bad); end
    checks++;
    if (ia.res_data !== 16'h0000) begin failures++; $display("FAIL midreset_data: got %h expected 0000", ia.res_data); end
  endtask

  initial begin
    test_reset();
    test_dht_cmd();
    test_gap();
    test_timeout();
    test_strobe_at_timeout();
    test_backpressure();
    test_auto();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
Sequences measurements for the two shared sensor front-ends (DHT11, HC-SR04) that sit behind the crossbar. Requests come from two requesters: the crossbar's UART command path and an internal periodic auto-poll timer. Only one sensor runs at a time. The block enforces the DHT11 minimum re-read gap, applies a response timeout, and returns each result through a valid/ready port toward the UART response path.

Parameters:
DHT_GAP_CYC, 100_000_000, minimum clk cycles between successive dht11_start pulses (1 s at 100 MHz)
TIMEOUT_CYC, 5_000_000, cycles to wait for data_available after a start pulse before reporting a timeout
AUTO_PERIOD_CYC, 0, auto-poll tick period in cycles; 0 disables auto-poll

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
cmd_req  in  1  command-path request, level; held until cmd_ack
cmd_sel  in  1  0 = DHT11, 1 = HC-SR04; sampled with cmd_req
cmd_ack  out  1  one-cycle pulse, registered, on the cycle after acceptance
auto_en  in  1  enables auto-poll ticks
dht11_start  out  1  one-cycle start pulse
dht11_data  in  16  DHT11 result
dht11_data_available  in  1  DHT11 result strobe
hc_sr04_start  out  1  one-cycle start pulse
hc_sr04_data  in  16  HC-SR04 result
hc_sr04_data_available  in  1  HC-SR04 result strobe
res_valid  out  1  result valid
res_ready  in  1  downstream accepts
res_data  out  16  latched result; 0 on timeout
res_src  out  1  sensor that produced the result (cmd_sel encoding)
res_status  out  2  00 OK, 01 TIMEOUT
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0. auto_pend=0, auto_next=DHT11, period counter=0. Gap counter is set to DHT_GAP_CYC, so the first DHT11 read is allowed immediately. A reset mid-operation aborts the measurement; a data strobe arriving after reset release is ignored.
- States: IDLE, GAP_WAIT, START, MEASURE, RESULT.
- IDLE:
  - cmd_req=1 has priority. Accept it, latch sel=cmd_sel, and pulse cmd_ack on the next cycle.
  - Otherwise, if auto_pend=1, latch sel=auto_next, clear auto_pend, and toggle auto_next.
  - After acceptance: go to START if sel=HC-SR04 or the gap has elapsed; otherwise go to GAP_WAIT.
- GAP_WAIT: stay until gap counter == DHT_GAP_CYC, then go to START.
- START: lasts one cycle. The start output selected by sel is high for exactly this cycle. The timeout counter is cleared. Next state is MEASURE.
  - Latency: request accepted in cycle N with no gap wait → start pulse in cycle N+1.
  - A DHT11 start clears the gap counter to 0.
- MEASURE:
  - The data_available strobe for sel latches the matching data, sets status=OK, and moves to RESULT.
  - The strobe from the non-selected sensor is ignored.
  - When the timeout counter reaches TIMEOUT_CYC-1: res_data=0, status=TIMEOUT, move to RESULT.
  - If the strobe and the timeout occur in the same cycle, the strobe wins.
  - Strobe in cycle M → res_valid=1 in cycle M+1.
- RESULT:
  - res_valid=1; res_data, res_src and res_status stay stable.
  - On res_valid & res_ready, go to IDLE; res_valid=0 on the next cycle.
  - No new request is accepted until the state returns to IDLE.
- Gap counter: saturating at DHT_GAP_CYC; increments every cycle in every state.
- Auto-poll: only when AUTO_PERIOD_CYC>0 and auto_en=1.
  - The period counter wraps at AUTO_PERIOD_CYC-1 and sets auto_pend on wrap.
  - A tick that arrives while auto_pend=1 is merged (dropped).
  - Ticks are never lost while the block is busy; they remain pending.
  - auto_en=0 holds the period counter at 0 and clears auto_pend.
- Width rules: counters are sized with $clog2(param+1). Comparisons are exact equality; no wrap past the saturation value.

Decomposition:
- Package sensor_sched_pkg holds:
  - state_e (IDLE, GAP_WAIT, START, MEASURE, RESULT)
  - sensor_e (SENS_DHT11=1'b0, SENS_HCSR04=1'b1)
  - status_e (ST_OK=2'b00, ST_TIMEOUT=2'b01)
- One natural sub-module: sched_counter, a parameterised counter with clear, enable, saturate-or-wrap mode and a terminal flag. It is instantiated for the gap, timeout and auto-period counters.

Test Plan:
(params DHT_GAP_CYC=50, TIMEOUT_CYC=100, AUTO_PERIOD_CYC=0 unless stated)
1. DHT11 command with dht11_data=16'h1616; strobe 10 cycles after the start pulse → cmd_ack one cycle after acceptance, dht11_start for 1 cycle, then res_valid with res_data=16'h1616, res_src=0, res_status=00. With res_ready=1 the block is in IDLE two cycles after the strobe.
2. Second DHT11 command issued 5 cycles after the first start pulse → block sits in GAP_WAIT; second dht11_start arrives exactly 50 cycles after the first.
3. HC-SR04 command, no strobe → hc_sr04_start pulse, then res_valid 100 cycles later with res_status=01, res_data=0, res_src=1.
4. HC-SR04 strobe with hc_sr04_data=16'd3214, res_ready held low for 20 cycles, cmd_req asserted meanwhile → res_valid and res_data remain stable throughout; no cmd_ack until after the res_valid/res_ready handshake.
5. AUTO_PERIOD_CYC=200, auto_en=1, res_ready=1 → start pulses alternate DHT11, HC-SR04, DHT11. A cmd_req coincident with an auto tick is served first; the pending auto request follows.
6. rst pulsed low during MEASURE, strobe arriving 3 cycles after release → all outputs 0, state IDLE, no res_valid produced.
